// File: rtl/axi_sram_pkg.sv
// Shared types and encodings for the AXI4 SRAM slave: FSM states, burst and response codes.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only full-word FIXED/INCR bursts are serviced; anything else is answered with SLVERR.
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd2) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_sram_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
module axi_sram_ram
  import axi_sram_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a word SRAM; one transaction outstanding, FIXED/INCR bursts only.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 4,
  parameter int MEM_WORDS    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]             s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]             s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int          AW    = $clog2(MEM_WORDS);
  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

  state_e                  state_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [29:0]             addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic                    oor_q;
  logic                    rd_first_q;

  logic        grant_rd, grant_wr, aw_acc, ar_acc, contested;
  logic        r_hs, last_beat, beat_oor, rd_bad;
  logic [29:0] addr_d;
  logic [29:0] ram_addr_full;
  logic        ram_re;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic        unused_ok;

  always_comb begin
    contested     = s_axi_awvalid && s_axi_arvalid;
    grant_rd      = s_axi_arvalid && (!s_axi_awvalid || rd_first_q);
    grant_wr      = s_axi_awvalid && !grant_rd;
    s_axi_arready = rst && (state_q == IDLE) && grant_rd;
    s_axi_awready = rst && (state_q == IDLE) && grant_wr;
    ar_acc        = s_axi_arvalid && s_axi_arready;
    aw_acc        = s_axi_awvalid && s_axi_awready;
    last_beat     = (beat_q == len_q);
    beat_oor      = (addr_q >= LIMIT);
    addr_d        = (burst_q == BURST_INCR) ? addr_q + 30'd1 : addr_q;
    r_hs          = (state_q == RDATA) && s_axi_rready;
    // The RAM is read one cycle ahead: the AR address on accept, the next beat on each handshake.
    ram_addr_full = addr_q;
    if (state_q == IDLE) ram_addr_full = s_axi_araddr[31:2];
    else if (r_hs)       ram_addr_full = addr_d;
    ram_re = ar_acc || r_hs;
    ram_we = 4'b0;
    if (rst && (state_q == WDATA) && s_axi_wvalid && !err_q && !beat_oor) ram_we = s_axi_wstrb;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      err_q      <= 1'b0;
      oor_q      <= 1'b0;
      rd_first_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          oor_q  <= 1'b0;
          beat_q <= 8'd0;
          if (ar_acc) begin
            id_q    <= s_axi_arid;
            addr_q  <= s_axi_araddr[31:2];
            len_q   <= s_axi_arlen;
            burst_q <= s_axi_arburst;
            err_q   <= req_err(s_axi_arsize, s_axi_arburst);
            state_q <= RDATA;
          end else if (aw_acc) begin
            id_q    <= s_axi_awid;
            addr_q  <= s_axi_awaddr[31:2];
            len_q   <= s_axi_awlen;
            burst_q <= s_axi_awburst;
            err_q   <= req_err(s_axi_awsize, s_axi_awburst);
            state_q <= WDATA;
          end
          // Priority only flips when a grant actually resolves contention.
          if ((ar_acc || aw_acc) && contested) rd_first_q <= !rd_first_q;
        end
        WDATA: begin
          if (s_axi_wvalid) begin
            if (s_axi_wlast != last_beat) err_q <= 1'b1;
            if (beat_oor) oor_q <= 1'b1;
            if (last_beat) begin
              state_q <= WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        WRESP: begin
          if (s_axi_bready) state_q <= IDLE;
        end
        RDATA: begin
          if (s_axi_rready) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axi_sram_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk    (clk),
    .addr_i (ram_addr_full[AW-1:0]),
    .re_i   (ram_re),
    .we_i   (ram_we),
    .wdata_i(s_axi_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    rd_bad       = err_q || beat_oor;
    s_axi_wready = (state_q == WDATA);
    s_axi_bvalid = (state_q == WRESP);
    s_axi_bid    = id_q;
    s_axi_bresp  = (s_axi_bvalid && (err_q || oor_q)) ? RESP_SLVERR : RESP_OKAY;
    s_axi_rvalid = (state_q == RDATA);
    s_axi_rid    = id_q;
    s_axi_rdata  = (s_axi_rvalid && !rd_bad) ? ram_rdata : 32'd0;
    s_axi_rresp  = (s_axi_rvalid && rd_bad) ? RESP_SLVERR : RESP_OKAY;
    s_axi_rlast  = s_axi_rvalid && last_beat;
  end

  assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], ram_addr_full[29:AW]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: single/burst access, byte strobes, arbitration, errors, reset.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  wstrb;
  logic [31:0] burst_d [4];
  int          checks = 0;
  int          errors = 0;

  axi_sram_slave #(.AXI_ID_WIDTH(4), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = awready;
      tick();
    end
    awvalid = 1'b0;
    chk("aw_accept", ok, 1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = arready;
      tick();
    end
    arvalid = 1'b0;
    chk("ar_accept", ok, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    logic ok;
    ok = 1'b0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = wready;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_accept", ok, 1);
  endtask

  task automatic wait_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
    logic ok;
    ok = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bvalid) begin
        ok = 1'b1;
        chk($sformatf("%s_bid", tag), bid, id);
        chk($sformatf("%s_bresp", tag), bresp, resp);
      end
      tick();
    end
    bready = 1'b0;
    chk($sformatf("%s_bseen", tag), ok, 1);
  endtask

  task automatic recv_r(input string tag, input logic [3:0] id, input logic [31:0] d,
                        input logic [1:0] resp, input logic last);
    logic ok;
    ok = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (rvalid) begin
        ok = 1'b1;
        chk($sformatf("%s_rid", tag), rid, id);
        chk($sformatf("%s_rdata", tag), rdata, d);
        chk($sformatf("%s_rresp", tag), rresp, resp);
        chk($sformatf("%s_rlast", tag), rlast, last);
      end
      tick();
    end
    rready = 1'b0;
    chk($sformatf("%s_rseen", tag), ok, 1);
  endtask

  task automatic write1(input string tag, input logic [31:0] addr, input logic [31:0] d,
                        input logic [3:0] s);
    send_aw(4'h1, addr, 8'd0, 3'd2, 2'b01);
    send_w(d, s, 1'b1);
    wait_b(tag, 4'h1, 2'b00);
  endtask

  task automatic read1(input string tag, input logic [31:0] addr, input logic [31:0] d);
    send_ar(4'h4, addr, 8'd0, 3'd2, 2'b01);
    recv_r(tag, 4'h4, d, 2'b00, 1'b1);
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    burst_d = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003};

    // Reset state, with requests pending that must not be granted.
    awvalid = 1'b1; arvalid = 1'b1;
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    awvalid = 1'b0; arvalid = 1'b0; rst = 1'b1;
    tick();

    // Single write then single read.
    send_aw(4'h3, 32'h0, 8'd0, 3'd2, 2'b01);
    send_w(32'hdeadbeef, 4'hf, 1'b1);
    wait_b("wr0", 4'h3, 2'b00);
    send_ar(4'h5, 32'h0, 8'd0, 3'd2, 2'b01);
    chk("rd0_rvalid_next_cycle", rvalid, 1);
    recv_r("rd0", 4'h5, 32'hdeadbeef, 2'b00, 1'b1);
    chk("rd0_rvalid_drop", rvalid, 0);

    // Byte-strobe merge.
    write1("wr4a", 32'h4, 32'h12345678, 4'hf);
    write1("wr4b", 32'h4, 32'h0000be00, 4'h2);
    read1("rd4", 32'h4, 32'h1234be78);

    // INCR burst write, streamed read, then stalled read.
    send_aw(4'h2, 32'h10, 8'd3, 3'd2, 2'b01);
    for (int k = 0; k < 4; k++) send_w(burst_d[k], 4'hf, k == 3);
    wait_b("wrb", 4'h2, 2'b00);
    send_ar(4'h6, 32'h10, 8'd3, 3'd2, 2'b01);
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stream%0d_rvalid", k), rvalid, 1);
      chk($sformatf("stream%0d_rdata", k), rdata, burst_d[k]);
      chk($sformatf("stream%0d_rlast", k), rlast, k == 3);
      tick();
    end
    rready = 1'b0;
    chk("stream_done", rvalid, 0);
    send_ar(4'h6, 32'h10, 8'd3, 3'd2, 2'b01);
    begin
      int b;
      b = 0;
      for (int c = 0; c < 7; c++) begin
        rready = (c % 2 == 0);
        #1;
        chk($sformatf("stall%0d_rvalid", c), rvalid, 1);
        chk($sformatf("stall%0d_rdata", c), rdata, burst_d[b]);
        chk($sformatf("stall%0d_rlast", c), rlast, b == 3);
        tick();
        if (rready) b++;
      end
    end
    rready = 1'b0;
    chk("stall_done", rvalid, 0);

    // Arbitration: read wins first after reset, write wins the next contest.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    awid = 4'h1; awaddr = 32'h20; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'h2; araddr = 32'h0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    #1;
    chk("arb1_arready", arready, 1);
    chk("arb1_awready", awready, 0);
    tick();
    arvalid = 1'b0;
    chk("arb1_aw_blocked", awready, 0);
    recv_r("arb1_rd", 4'h2, 32'hdeadbeef, 2'b00, 1'b1);
    #1;
    chk("arb1_aw_next", awready, 1);
    tick();
    awvalid = 1'b0;
    send_w(32'h5555aaaa, 4'hf, 1'b1);
    wait_b("arb1_wr", 4'h1, 2'b00);
    awid = 4'h1; awaddr = 32'h20; awvalid = 1'b1;
    arid = 4'h2; araddr = 32'h20; arvalid = 1'b1;
    #1;
    chk("arb2_awready", awready, 1);
    chk("arb2_arready", arready, 0);
    tick();
    awvalid = 1'b0;
    chk("arb2_ar_blocked", arready, 0);
    send_w(32'h0badf00d, 4'hf, 1'b1);
    wait_b("arb2_wr", 4'h1, 2'b00);
    send_ar(4'h2, 32'h20, 8'd0, 3'd2, 2'b01);
    recv_r("arb2_rd", 4'h2, 32'h0badf00d, 2'b00, 1'b1);

    // Top-of-memory crossing and WRAP rejection.
    write1("wrtop", 32'hffc, 32'hcafef00d, 4'hf);
    send_ar(4'h7, 32'hffc, 8'd1, 3'd2, 2'b01);
    recv_r("oor_b0", 4'h7, 32'hcafef00d, 2'b00, 1'b0);
    recv_r("oor_b1", 4'h7, 32'h0, 2'b10, 1'b1);
    send_aw(4'h1, 32'h0, 8'd0, 3'd2, 2'b10);
    send_w(32'h11111111, 4'hf, 1'b1);
    wait_b("wrap", 4'h1, 2'b10);
    read1("wrap_mem", 32'h0, 32'hdeadbeef);

    // Reset during beat 2 of an 8-beat write.
    send_aw(4'h9, 32'h40, 8'd7, 3'd2, 2'b01);
    send_w(32'h40404040, 4'hf, 1'b0);
    send_w(32'h41414141, 4'hf, 1'b0);
    wdata = 32'h42424242; wstrb = 4'hf; wvalid = 1'b1; rst = 1'b0;
    tick();
    wvalid = 1'b0;
    chk("mrst_bvalid", bvalid, 0);
    chk("mrst_wready", wready, 0);
    chk("mrst_awready", awready, 0);
    chk("mrst_arready", arready, 0);
    chk("mrst_rvalid", rvalid, 0);
    tick();
    rst = 1'b1; bready = 1'b1;
    tick();
    chk("mrst_no_b", bvalid, 0);
    bready = 1'b0;
    send_ar(4'h3, 32'h40, 8'd1, 3'd2, 2'b01);
    recv_r("mrst_b0", 4'h3, 32'h40404040, 2'b00, 1'b0);
    recv_r("mrst_b1", 4'h3, 32'h41414141, 2'b00, 1'b1);
    write1("mrst_wr", 32'h48, 32'h48484848, 4'hf);
    read1("mrst_rd", 32'h48, 32'h48484848);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
